ifw_pad_cnt_fsm: RTL

IFW_PAD_CNT_FSM -- requirements
Module: ifw_pad_cnt_fsm

---
 rtl/ifw_pad_cnt_fsm_pkg.sv | 22 ++
 rtl/ifw_pad_cnt_fsm_if.sv | 48 ++++
 rtl/count_yi_v5.sv | 30 +++
 rtl/ifw_pad_cnt_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ifw_pad_cnt_fsm_pkg.sv
// Shared types and defaults for the padded row-write sequencer.
// State encodings, cfg_mode bit positions and parameter defaults.
package ifw_pad_cnt_fsm_pkg;

    localparam int DEF_CNT00_WIDTH   = 10;
    localparam int DEF_CNT01_WIDTH   = 10;
    localparam int DEF_WS_ADDR_WIDTH = 10;
    localparam int DEF_PAD_WIDTH     = 4;
    localparam int DEF_NUM_BUF       = 8;

    localparam int CFG_LEFT_BIT  = 0;
    localparam int CFG_RIGHT_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEFT   = 3'd1,
        ST_NORMAL = 3'd2,
        ST_RIGH   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/ifw_pad_cnt_fsm_if.sv
// Control, FIFO handshake and SRAM write bundle of the sequencer.
// master drives configuration/FIFO side, slave is the sequencer.
interface ifw_pad_cnt_fsm_if #(
    parameter int CNT00_WIDTH   = ifw_pad_cnt_fsm_pkg::DEF_CNT00_WIDTH,
    parameter int CNT01_WIDTH   = ifw_pad_cnt_fsm_pkg::DEF_CNT01_WIDTH,
    parameter int WS_ADDR_WIDTH = ifw_pad_cnt_fsm_pkg::DEF_WS_ADDR_WIDTH,
    parameter int PAD_WIDTH     = ifw_pad_cnt_fsm_pkg::DEF_PAD_WIDTH,
    parameter int NUM_BUF       = ifw_pad_cnt_fsm_pkg::DEF_NUM_BUF
);

    logic                     start;
    logic [1:0]               cfg_mode;
    logic                     din_valid;
    logic                     din_ready;
    logic [CNT00_WIDTH-1:0]   cnt00_final;
    logic [CNT01_WIDTH-1:0]   cnt01_final;
    logic [WS_ADDR_WIDTH-1:0] srad_final;
    logic [PAD_WIDTH-1:0]     pad_left_num;
    logic [PAD_WIDTH-1:0]     pad_right_num;
    logic                     wr_en;
    logic                     wr_pad;
    logic [WS_ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_BUF-1:0]       wr_buf_sel;
    logic                     busy;
    logic                     done;
    logic [2:0]               curr_state;
    logic [CNT00_WIDTH-1:0]   cnt00;
    logic [CNT01_WIDTH-1:0]   cnt01;

    modport master (
        output start, cfg_mode, din_valid,
        output cnt00_final, cnt01_final, srad_final,
        output pad_left_num, pad_right_num,
        input  din_ready, wr_en, wr_pad, wr_addr,
        input  wr_buf_sel, busy, done, curr_state,
        input  cnt00, cnt01
    );

    modport slave (
        input  start, cfg_mode, din_valid,
        input  cnt00_final, cnt01_final, srad_final,
        input  pad_left_num, pad_right_num,
        output din_ready, wr_en, wr_pad, wr_addr,
        output wr_buf_sel, busy, done, curr_state,
        output cnt00, cnt01
    );

endinterface

// File: rtl/count_yi_v5.sv
// Enabled up-counter that wraps to 0 after reaching its final value.
// Synchronous clear restarts it at the beginning of a frame.
module count_yi_v5 #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_final_number,
    output logic             o_last,
    output logic [WIDTH-1:0] o_total_q
);

    logic [WIDTH-1:0] r_q;

    assign o_last    = (r_q == i_final_number);
    assign o_total_q = r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= o_last ? '0 : r_q + 1'b1;
        end
    end

endmodule

// File: rtl/ifw_pad_cnt_fsm.sv
// Row-write sequencer: optional left pad, FIFO data, optional right pad
// per row, rotating one-hot row buffer and wrapping SRAM address.
module ifw_pad_cnt_fsm
    import ifw_pad_cnt_fsm_pkg::*;
#(
    parameter int CNT00_WIDTH   = DEF_CNT00_WIDTH,
    parameter int CNT01_WIDTH   = DEF_CNT01_WIDTH,
    parameter int WS_ADDR_WIDTH = DEF_WS_ADDR_WIDTH,
    parameter int PAD_WIDTH     = DEF_PAD_WIDTH,
    parameter int NUM_BUF       = DEF_NUM_BUF
) (
    input logic clk,
    input logic reset,
    ifw_pad_cnt_fsm_if.slave bus
);

    state_t r_state;
    state_t w_next;
    state_t w_row_next;

    logic [1:0]               r_mode;
    logic [CNT00_WIDTH-1:0]   r_c00_fin;
    logic [CNT01_WIDTH-1:0]   r_c01_fin;
    logic [WS_ADDR_WIDTH-1:0] r_srad_fin;
    logic [PAD_WIDTH-1:0]     r_pad_l;
    logic [PAD_WIDTH-1:0]     r_pad_r;
    logic [NUM_BUF-1:0]       r_buf_sel;

    logic                     w_start;
    logic                     w_left_go_new;
    logic                     w_left_go;
    logic                     w_right_go;
    logic                     w_wr_en;
    logic                     w_wr_pad;
    logic                     w_c00_en;
    logic                     w_c01_en;
    logic                     w_row_end;
    logic                     w_c00_last;
    logic                     w_c01_last;
    logic                     w_pad_last;
    logic                     w_addr_last_unused;
    logic [PAD_WIDTH-1:0]     w_pad_fin;
    logic [PAD_WIDTH-1:0]     w_pad_q_unused;
    logic [CNT00_WIDTH-1:0]   w_c00_q;
    logic [CNT01_WIDTH-1:0]   w_c01_q;
    logic [WS_ADDR_WIDTH-1:0] w_addr_q;

    assign w_start = (r_state == ST_IDLE) && bus.start;

    // Pad decisions for a new frame use the raw inputs, later rows the latched copy
    assign w_left_go_new = bus.cfg_mode[CFG_LEFT_BIT]
                         && (bus.pad_left_num != '0);
    assign w_left_go     = r_mode[CFG_LEFT_BIT] && (r_pad_l != '0);
    assign w_right_go    = r_mode[CFG_RIGHT_BIT] && (r_pad_r != '0);

    assign w_wr_pad = (r_state == ST_LEFT) || (r_state == ST_RIGH);
    assign w_wr_en  = w_wr_pad
                    || ((r_state == ST_NORMAL) && bus.din_valid);

    assign w_c00_en = (r_state == ST_NORMAL) && bus.din_valid;

    assign w_pad_fin = (r_state == ST_LEFT) ? r_pad_l - 1'b1
                                            : r_pad_r - 1'b1;

    assign w_row_end = (w_c00_en && w_c00_last && !w_right_go)
                     || ((r_state == ST_RIGH) && w_pad_last);

    assign w_c01_en = w_row_end && !w_c01_last;

    assign w_row_next = w_c01_last ? ST_DONE
                      : (w_left_go ? ST_LEFT : ST_NORMAL);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = w_left_go_new ? ST_LEFT : ST_NORMAL;
                end
            end
            ST_LEFT: begin
                if (w_pad_last) begin
                    w_next = ST_NORMAL;
                end
            end
            ST_NORMAL: begin
                if (w_c00_en && w_c00_last) begin
                    w_next = w_right_go ? ST_RIGH : w_row_next;
                end
            end
            ST_RIGH: begin
                if (w_pad_last) begin
                    w_next = w_row_next;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= '0;
            r_c00_fin  <= '0;
            r_c01_fin  <= '0;
            r_srad_fin <= '0;
            r_pad_l    <= '0;
            r_pad_r    <= '0;
            r_buf_sel  <= {{(NUM_BUF-1){1'b0}}, 1'b1};
        end else if (w_start) begin
            r_mode     <= bus.cfg_mode;
            r_c00_fin  <= bus.cnt00_final;
            r_c01_fin  <= bus.cnt01_final;
            r_srad_fin <= bus.srad_final;
            r_pad_l    <= bus.pad_left_num;
            r_pad_r    <= bus.pad_right_num;
            r_buf_sel  <= {{(NUM_BUF-1){1'b0}}, 1'b1};
        end else if (w_c01_en) begin
            r_buf_sel  <= {r_buf_sel[NUM_BUF-2:0],
                           r_buf_sel[NUM_BUF-1]};
        end
    end

    count_yi_v5 #(.WIDTH(CNT00_WIDTH)) u_cnt00 (
        .clk            (clk),
        .rst_n          (reset),
        .i_clr          (w_start),
        .i_en           (w_c00_en),
        .i_final_number (r_c00_fin),
        .o_last         (w_c00_last),
        .o_total_q      (w_c00_q)
    );

    count_yi_v5 #(.WIDTH(CNT01_WIDTH)) u_cnt01 (
        .clk            (clk),
        .rst_n          (reset),
        .i_clr          (w_start),
        .i_en           (w_c01_en),
        .i_final_number (r_c01_fin),
        .o_last         (w_c01_last),
        .o_total_q      (w_c01_q)
    );

    // Pad counter serves both sides; it wraps to 0 on its last pad
    count_yi_v5 #(.WIDTH(PAD_WIDTH)) u_pad (
        .clk            (clk),
        .rst_n          (reset),
        .i_clr          (w_start),
        .i_en           (w_wr_pad),
        .i_final_number (w_pad_fin),
        .o_last         (w_pad_last),
        .o_total_q      (w_pad_q_unused)
    );

    count_yi_v5 #(.WIDTH(WS_ADDR_WIDTH)) u_addr (
        .clk            (clk),
        .rst_n          (reset),
        .i_clr          (w_start),
        .i_en           (w_wr_en),
        .i_final_number (r_srad_fin),
        .o_last         (w_addr_last_unused),
        .o_total_q      (w_addr_q)
    );

    assign bus.din_ready  = (r_state == ST_NORMAL);
    assign bus.wr_en      = w_wr_en;
    assign bus.wr_pad     = w_wr_pad;
    assign bus.wr_addr    = w_addr_q;
    assign bus.wr_buf_sel = r_buf_sel;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.curr_state = r_state;
    assign bus.cnt00      = w_c00_q;
    assign bus.cnt01      = w_c01_q;

endmodule
